// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and default sizing for the hazard controller.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_MAC   = 2'd2
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_CUS    = 7'b0001011;

  localparam int unsigned MAC_LAT_DEF   = 3;
  localparam int unsigned FLUSH_LEN_DEF = 2;
  localparam int unsigned CW_DEF        = 4;

  // Opcodes whose rs2 is read in EX and cannot take the load-data bypass.
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_CUS);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare between the IF/ID consumer and the ID/EX load.
module pipe_hazard_ctrl_load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [6:0] id_op,
  input  logic [4:0] id_rs2,
  input  logic [6:0] ex_op,
  input  logic [4:0] ex_rd,
  output logic       hit_c
);

  // rs1 is bypassed from load data inside EX, so only rs2 users are checked.
  assign hit_c = (ex_op == OP_LOAD) && (ex_rd != 5'd0) &&
                 uses_rs2(id_op) && (id_rs2 == ex_rd);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/bubble/flush controller: branch squash, multi-cycle MAC hold,
// load-use interlock and external halts, decoded Mealy-style from one FSM.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MAC_LAT   = MAC_LAT_DEF,
  parameter int unsigned FLUSH_LEN = FLUSH_LEN_DEF,
  parameter int unsigned CW        = CW_DEF
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        ext_halt,
  input  logic        mem_busy,
  input  logic [31:0] id_inst,
  input  logic [31:0] ex_inst,
  input  logic        ex_is_cus,
  input  logic        branch_req,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        bubble_ex,
  output logic        flush_id,
  output logic        branch_taken,
  output logic        mac_start,
  output logic        mac_done,
  output logic [1:0]  state
);

  // Reject configurations the counter cannot represent.
  if ((MAC_LAT < 1) || (MAC_LAT > 15) || (FLUSH_LEN < 1) || (FLUSH_LEN > 15) ||
      (CW < 1) || (CW > 16) || (FLUSH_LEN > (32'd1 << CW)) ||
      (MAC_LAT > (32'd1 << CW) + 1)) begin : g_cfg_err
    $error("pipe_hazard_ctrl: illegal MAC_LAT/FLUSH_LEN/CW");
  end

  localparam logic [CW-1:0] FLUSH_INIT = CW'(FLUSH_LEN - 1);
  localparam logic [CW-1:0] MAC_INIT   = CW'((MAC_LAT >= 2) ? (MAC_LAT - 2) : 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          halt;
  logic          load_use;
  logic          mac_req;
  logic          unused_id_bits;

  assign halt    = ext_halt | mem_busy;
  assign mac_req = ex_is_cus && (ex_inst != 32'd0);
  assign unused_id_bits = ^{id_inst[31:25], id_inst[19:7]};

  pipe_hazard_ctrl_load_use_detect u_lud (
    .id_op  (id_inst[6:0]),
    .id_rs2 (id_inst[24:20]),
    .ex_op  (ex_inst[6:0]),
    .ex_rd  (ex_inst[11:7]),
    .hit_c  (load_use)
  );

  // State and counter register; halts freeze them via the next-state logic.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and Mealy outputs. Priority: reset, halt, branch, MAC, load-use.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex     = 1'b0;
    bubble_ex    = 1'b0;
    flush_id     = 1'b0;
    branch_taken = 1'b0;
    mac_start    = 1'b0;
    mac_done     = 1'b0;

    if (RES) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (halt) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
    end else begin
      unique case (state_q)
        ST_FLUSH: begin
          flush_id  = 1'b1;
          bubble_ex = 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_MAC: begin
          if (cnt_q == '0) begin
            mac_done = 1'b1;
            state_d  = ST_RUN;
          end else begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
            cnt_d    = cnt_q - CW'(1);
          end
        end
        default: begin
          if (branch_req) begin
            branch_taken = 1'b1;
            flush_id     = 1'b1;
            bubble_ex    = 1'b1;
            state_d      = ST_FLUSH;
            cnt_d        = FLUSH_INIT;
          end else if (mac_req) begin
            mac_start = 1'b1;
            if (MAC_LAT == 1) begin
              mac_done = 1'b1;
            end else begin
              stall_if = 1'b1;
              stall_id = 1'b1;
              stall_ex = 1'b1;
              state_d  = ST_MAC;
              cnt_d    = MAC_INIT;
            end
          end else if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end
        end
      endcase
    end
  end

  // Debug state view, forced to RUN while reset is asserted.
  assign state = RES ? 2'b00 : 2'(state_q);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: cycle-level behavioural model plus directed literal checks
// followed by randomized traffic.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MAC_LAT   = 3;
  localparam int unsigned FLUSH_LEN = 2;
  localparam int unsigned CW        = 4;

  localparam logic [31:0] MAC_I      = 32'h0020_838B;
  localparam logic [31:0] LW_X5      = 32'h0002_A283;
  localparam logic [31:0] LW_X0      = 32'h0002_A003;
  localparam logic [31:0] ADD_RS2_X5 = 32'h0050_8333;
  localparam logic [31:0] ADD_RS1_X5 = 32'h0012_8333;
  localparam logic [31:0] ADD_X1_X0  = 32'h0000_8333;

  logic        CLK = 1'b0;
  logic        RES, ext_halt, mem_busy, ex_is_cus, branch_req;
  logic [31:0] id_inst, ex_inst;
  logic        stall_if, stall_id, stall_ex, bubble_ex, flush_id, branch_taken, mac_start, mac_done;
  logic [1:0]  state;
  logic        s1_if, s1_id, s1_ex, s1_bub, s1_fl, s1_bt, s1_ms, s1_md;
  logic [1:0]  s1_state;

  int vectors = 0;
  int errors  = 0;
  int cycle   = 0;

  // Model state: extra squash cycles left, and MAC cycles left after the start cycle.
  int m_flush = 0;
  int m_mac   = 0;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.MAC_LAT(MAC_LAT), .FLUSH_LEN(FLUSH_LEN), .CW(CW)) dut (
    .CLK(CLK), .RES(RES), .ext_halt(ext_halt), .mem_busy(mem_busy),
    .id_inst(id_inst), .ex_inst(ex_inst), .ex_is_cus(ex_is_cus), .branch_req(branch_req),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .bubble_ex(bubble_ex),
    .flush_id(flush_id), .branch_taken(branch_taken), .mac_start(mac_start),
    .mac_done(mac_done), .state(state)
  );

  pipe_hazard_ctrl #(.MAC_LAT(1), .FLUSH_LEN(FLUSH_LEN), .CW(CW)) dut1 (
    .CLK(CLK), .RES(RES), .ext_halt(ext_halt), .mem_busy(mem_busy),
    .id_inst(id_inst), .ex_inst(ex_inst), .ex_is_cus(ex_is_cus), .branch_req(branch_req),
    .stall_if(s1_if), .stall_id(s1_id), .stall_ex(s1_ex), .bubble_ex(s1_bub),
    .flush_id(s1_fl), .branch_taken(s1_bt), .mac_start(s1_ms),
    .mac_done(s1_md), .state(s1_state)
  );

  wire [7:0] ctl = {stall_if, stall_id, stall_ex, bubble_ex, flush_id, branch_taken, mac_start, mac_done};
  wire [9:0] got = {ctl, state};

  function automatic bit load_use_hit(input logic [31:0] id, input logic [31:0] ex);
    logic [6:0] op;
    op = id[6:0];
    return (ex[6:0] == 7'b0000011) && (ex[11:7] != 5'd0) &&
           (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011 || op == 7'b0001011) &&
           (id[24:20] == ex[11:7]);
  endfunction

  // Expected {stall_if, stall_id, stall_ex, bubble_ex, flush_id, branch_taken, mac_start, mac_done, state}.
  function automatic logic [9:0] expect_now();
    bit sif, sid, sex, bub, fl, bt, ms, md;
    logic [1:0] st;
    {sif, sid, sex, bub, fl, bt, ms, md} = 8'd0;
    st = (m_flush > 0) ? 2'd1 : (m_mac > 0) ? 2'd2 : 2'd0;
    if (RES) return 10'd0;
    if (ext_halt || mem_busy) begin
      sif = 1; sid = 1; sex = 1;
    end else if (m_flush > 0) begin
      fl = 1; bub = 1;
    end else if (m_mac > 0) begin
      if (m_mac == 1) md = 1;
      else begin sif = 1; sid = 1; sex = 1; end
    end else if (branch_req) begin
      bt = 1; fl = 1; bub = 1;
    end else if (ex_is_cus && ex_inst != 32'd0) begin
      ms = 1;
      if (MAC_LAT == 1) md = 1;
      else begin sif = 1; sid = 1; sex = 1; end
    end else if (load_use_hit(id_inst, ex_inst)) begin
      sif = 1; sid = 1; bub = 1;
    end
    return {sif, sid, sex, bub, fl, bt, ms, md, st};
  endfunction

  // Advance the model on the same edge the DUT samples its inputs.
  always @(posedge CLK) begin
    cycle++;
    if (RES) begin
      m_flush = 0; m_mac = 0;
    end else if (ext_halt || mem_busy) begin
      m_flush = m_flush;
    end else if (m_flush > 0) begin
      m_flush--;
    end else if (m_mac > 0) begin
      m_mac--;
    end else if (branch_req) begin
      m_flush = FLUSH_LEN;
    end else if (ex_is_cus && ex_inst != 32'd0 && MAC_LAT > 1) begin
      m_mac = MAC_LAT - 1;
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge CLK) begin
    logic [9:0] exp_v;
    exp_v = expect_now();
    vectors++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL model_cmp cycle %0d: got %b want %b (if id ex bub fl bt ms md st)", cycle, got, exp_v);
    end
  end

  task automatic lit(input string nm, input logic [31:0] g, input logic [31:0] w);
    vectors++;
    if (g !== w) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h want %0h", nm, cycle, g, w);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic mid();
    @(negedge CLK); #1;
  endtask

  initial begin
    RES = 1; ext_halt = 0; mem_busy = 0; branch_req = 1; ex_is_cus = 1;
    ex_inst = MAC_I; id_inst = 32'd0;

    // Reset dominates branch and MAC requests.
    mid(); lit("rst0_ctl", 32'(ctl), 0); lit("rst0_state", 32'(state), 0);
    tick(); mid(); lit("rst1_ctl", 32'(ctl), 0); lit("rst1_state", 32'(state), 0);

    // Release into a held branch: one taken cycle, then FLUSH_LEN squash cycles.
    tick(); RES = 0; mid(); lit("rel_bt", 32'(branch_taken), 1); lit("rel_fl", 32'(flush_id), 1);
    tick(); ex_is_cus = 0; ex_inst = 0; mid();
    lit("fl1_bt", 32'(branch_taken), 0); lit("fl1_fl", 32'(flush_id), 1); lit("fl1_st", 32'(state), 1);
    tick(); mid(); lit("fl2_bub", 32'(bubble_ex), 1); lit("fl2_st", 32'(state), 1); lit("fl2_bt", 32'(branch_taken), 0);
    tick(); branch_req = 0; mid(); lit("fl3_st", 32'(state), 0); lit("fl3_fl", 32'(flush_id), 0);

    // MAC occupies EX for MAC_LAT cycles; the MAC_LAT=1 instance never stalls.
    tick(); ex_is_cus = 1; ex_inst = MAC_I; mid();
    lit("mac0_start", 32'(mac_start), 1); lit("mac0_sex", 32'(stall_ex), 1);
    lit("l1_startdone", 32'({s1_ms, s1_md, s1_ex}), 32'b110);
    tick(); mid(); lit("mac1_sex", 32'(stall_ex), 1); lit("mac1_start", 32'(mac_start), 0); lit("mac1_st", 32'(state), 2);
    tick(); mid(); lit("mac2_done", 32'(mac_done), 1); lit("mac2_sex", 32'(stall_ex), 0);

    // Load-use on rs2 stalls; rs1 match and rd=x0 do not.
    tick(); ex_is_cus = 0; ex_inst = LW_X5; id_inst = ADD_RS2_X5; mid();
    lit("lu_rs2", 32'({stall_if, stall_id, bubble_ex, stall_ex}), 32'b1110);
    tick(); id_inst = ADD_RS1_X5; mid(); lit("lu_rs1", 32'({stall_if, stall_id, bubble_ex}), 0);
    tick(); ex_inst = LW_X0; id_inst = ADD_X1_X0; mid(); lit("lu_x0", 32'({stall_if, stall_id, bubble_ex}), 0);

    // Halt during MAC delays mac_done by the halt length.
    tick(); ex_inst = MAC_I; ex_is_cus = 1; id_inst = 0; mid(); lit("h_start", 32'(mac_start), 1);
    tick(); ext_halt = 1; mid(); lit("h1", 32'({stall_ex, mac_done}), 32'b10);
    tick(); mid(); lit("h2", 32'({stall_ex, mac_done}), 32'b10);
    tick(); mid(); lit("h3", 32'({stall_ex, mac_done, mac_start}), 32'b100);
    tick(); ext_halt = 0; mid(); lit("h4", 32'({stall_ex, mac_done}), 32'b10);
    tick(); mid(); lit("h5_done", 32'({stall_ex, mac_done}), 32'b01);

    // Branch and load-use together: branch wins, no front-end stall.
    tick(); ex_is_cus = 0; ex_inst = LW_X5; id_inst = ADD_RS2_X5; branch_req = 1; mid();
    lit("br_lu", 32'({branch_taken, stall_if, stall_id, bubble_ex, flush_id}), 32'b10011);
    tick(); branch_req = 0; ex_inst = 0; id_inst = 0; mid();
    tick(); mid();

    // Reset mid-MAC drops the pending done; a new MAC starts cleanly.
    tick(); ex_is_cus = 1; ex_inst = MAC_I; mid(); lit("r_start", 32'(mac_start), 1);
    tick(); RES = 1; mid(); lit("r_nodone", 32'(mac_done), 0); lit("r_ctl", 32'(ctl), 0);
    tick(); RES = 0; mid(); lit("r_restart", 32'(mac_start), 1); lit("r_state", 32'(state), 0);
    tick(); mid(); tick(); mid(); lit("r_done", 32'(mac_done), 1);
    tick(); ex_is_cus = 0; ex_inst = 0;

    // Randomized traffic checked by the model process.
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] ops [5];
      ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0001011, 7'b0010011};
      RES        = ($urandom_range(0, 49) == 0);
      ext_halt   = ($urandom_range(0, 9) == 0);
      mem_busy   = ($urandom_range(0, 9) == 0);
      branch_req = ($urandom_range(0, 5) == 0);
      ex_is_cus  = 1'b0;
      case ($urandom_range(0, 3))
        0: ex_inst = 32'd0;
        1: begin ex_inst = {25'($urandom), 7'b0001011}; ex_is_cus = ($urandom_range(0, 2) != 0); end
        2: ex_inst = {12'($urandom), 5'($urandom), 3'b010, 5'($urandom_range(0, 3)), 7'b0000011};
        default: begin ex_inst = $urandom; ex_is_cus = ($urandom_range(0, 7) == 0); end
      endcase
      if ($urandom_range(0, 15) == 0) begin ex_inst = 32'd0; ex_is_cus = 1'b1; end
      id_inst = {7'($urandom), 5'($urandom_range(0, 3)), 13'($urandom), ops[$urandom_range(0, 4)]};
      tick();
    end

    RES = 1; tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RV32 pipeline. It turns the raw EX-stage jump decision, load-use dependencies, the multi-cycle custom MAC instruction (opcode 0001011) and external memory/debug halts into per-stage stall, bubble and flush controls. It replaces the ad-hoc branch suppression buffers inside the execute stage with one registered FSM.

Parameters:
MAC_LAT, 3, cycles the custom MAC occupies EX (legal 1..15)
FLUSH_LEN, 2, extra squash cycles after a taken branch/jump (legal 1..15)
CW, 4, width of the internal cycle counter

Ports:
CLK  in  1  clock, all state on rising edge
RES  in  1  synchronous active-high reset
ext_halt  in  1  debug/system halt request, level
mem_busy  in  1  data memory not ready for the MEM-stage access, level
id_inst  in  32  instruction currently in IF/ID
ex_inst  in  32  instruction currently in ID/EX (0 = bubble)
ex_is_cus  in  1  ID/EX holds custom MAC
branch_req  in  1  raw taken decision from EX (JAL, JALR or taken Bxx), unfiltered
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID
stall_ex  out  1  hold ID/EX and EX/MEM (drives execute HLT)
bubble_ex  out  1  load zero into ID/EX next edge
flush_id  out  1  load zero into IF/ID next edge
branch_taken  out  1  filtered redirect, exactly one cycle per real branch
mac_start  out  1  one-cycle pulse, MAC begins
mac_done  out  1  one-cycle pulse, MAC result valid for EX/MEM capture
state  out  2  debug: 0 RUN, 1 FLUSH, 2 MAC

Behaviour:
- Reset (RES=1 at edge): state RUN, counter 0. While RES is high, all outputs are 0 combinationally.
- halt = ext_halt | mem_busy. While halt: stall_if=stall_id=stall_ex=1; branch_taken, bubble_ex, flush_id, mac_start and mac_done are 0. State and counter are frozen. Inputs are re-evaluated on the first cycle after halt drops.
- Outputs are Mealy: decoded from the registered state, counter and current inputs. Priority: RES > halt > branch > MAC > load-use.
- RUN, branch_req=1: branch_taken=1, flush_id=1, bubble_ex=1. Next state FLUSH, counter=FLUSH_LEN-1.
- FLUSH: flush_id=1, bubble_ex=1, branch_taken=0, branch_req ignored. Decrement the counter; at 0, next state is RUN. Total squash is FLUSH_LEN+1 cycles including the taken cycle.
- RUN, ex_is_cus=1, ex_inst!=0, no branch:
  - MAC_LAT=1: mac_start=mac_done=1 in the same cycle, no stall, stay RUN.
  - Otherwise: mac_start=1 and stall_if=stall_id=stall_ex=1; next state MAC, counter=MAC_LAT-2.
- MAC: stall_if/id/ex=1 while counter!=0; decrement each cycle. At counter=0: stalls=0, mac_done=1, next state RUN, so EX/MEM captures the result on that edge. A MAC therefore holds EX for exactly MAC_LAT cycles.
- Load-use (RUN, no branch, no MAC start):
  - Condition: ex_inst[6:0]=0000011, ex_inst[11:7]!=0, id_inst opcode in {0110011, 0100011, 1100011, 0001011}, and id_inst[24:20]==ex_inst[11:7].
  - Response: stall_if=stall_id=1 and bubble_ex=1 for one cycle; no state change.
  - rs1 is forwarded from load data inside EX, so rs1 matches never stall.
- RES during MAC or FLUSH: return to RUN with no mac_done and no branch_taken pulse.
- Counter arithmetic is unsigned CW bits and never underflows. Parameters outside their legal range are a configuration error, checked with an elaboration assertion.

Decomposition:
- Shared package/header (config.vh): opcode constants (LOAD, STORE, BRANCH, OP, CUS), state encodings RUN/FLUSH/MAC, and the MAC_LAT/FLUSH_LEN defaults.
- One natural sub-module, load_use_detect: combinational id_inst/ex_inst compare. The FSM and counter stay in pipe_hazard_ctrl.

Test Plan:
1. RES=1 for 2 cycles with branch_req=1 and ex_is_cus=1 -> all outputs 0, state=0. Release -> branch_taken=1 on the first RUN cycle.
2. branch_req held high 5 cycles, FLUSH_LEN=2 -> branch_taken=1 only in cycle 0; flush_id=bubble_ex=1 in cycles 0..2; state 1 in cycles 1..2; back to 0 in cycle 3.
3. ex_inst=custom MAC, MAC_LAT=3 -> mac_start in cycle 0; stall_ex=1 in cycles 0..1; mac_done=1 with stall_ex=0 in cycle 2. Repeat with MAC_LAT=1 -> start and done in the same cycle, no stall.
4. ex_inst=lw x5 (0x0002A283), id_inst=add x6,x1,x5 -> stall_if=stall_id=bubble_ex=1 for one cycle. Same with id_inst=add x6,x5,x1 -> no stall. Same with ex rd=x0 -> no stall.
5. ext_halt=1 for 3 cycles starting in MAC cycle 1 -> stalls held, mac_done delayed exactly 3 cycles. Then branch_req and load-use together -> branch wins, no separate load-use stall.
6. RES asserted in MAC cycle 1 -> no mac_done. Next cycle state=0, and a fresh ex_is_cus restarts with mac_start.
